inverter_sequencer: RTL
=======================

Name: inverter_sequencer

Overview:
Start/stop and protection controller for the three-phase sine-triangle PWM inverter datapath. It ramps the modulation index fed to the sine generator for soft start and soft stop. It takes the raw per-phase comparator decisions and drives the six complementary gate outputs with dead-time insertion. A fault input latches a shutdown state.

Parameters:
DEADTIME, 8, clocks both gates of a phase are held low on every transition; must be >= 1.
RAMP_DIV, 1024, clocks between modulation-index steps; must be >= 1.
RAMP_STEP, 16, modulation-index increment/decrement per step.
MI_MAX, 65535, full-run modulation index (16-bit).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level/pulse; request run.
stop  input  1  level/pulse; request soft stop.
fault_n  input  1  active-low fault; synchronous to clk.
clear  input  1  pulse; leave FAULT.
raw_a, raw_b, raw_c  input  1 each  comparator decisions (sine > triangle), clk domain.
mod_index  output  16  scale factor to the sine generator.
Va, Van, Vb, Vbn, Vc, Vcn  output  1 each  registered gate drives.
state  output  3  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4.
fault_latched  output  1  high iff state==FAULT.

Behaviour:
- Reset (rst_n low, async): state=IDLE, mod_index=0, all six gates 0, fault_latched=0, prescaler=0, dead-time counters=0.
- Priority each edge: fault_n low > stop > start. start and stop in the same cycle: stop wins.
- IDLE: gates 0, mod_index=0. start -> RAMP_UP.
- RAMP_UP:
  - Prescaler counts 0..RAMP_DIV-1. On wrap, mod_index = min(mod_index+RAMP_STEP, MI_MAX); the sum is computed at 17 bits, no wrap-around.
  - Entering RUN happens on the same edge mod_index becomes MI_MAX.
  - stop -> RAMP_DOWN. mod_index is held and the prescaler restarts at 0.
- RUN: mod_index=MI_MAX. stop -> RAMP_DOWN.
- RAMP_DOWN:
  - On prescaler wrap, mod_index = max(mod_index-RAMP_STEP, 0); saturates, no underflow.
  - Reaching 0 -> IDLE on that edge; gates go 0 on the same edge.
  - start (without stop) -> RAMP_UP, mod_index held.
- Prescaler resets to 0 on every state change.
- FAULT:
  - Entered from any state on the first edge that samples fault_n=0.
  - On that edge: all gates 0 and mod_index=0.
  - Exit to IDLE only on an edge with clear=1 and fault_n=1. clear while fault_n=0 is ignored.
  - start and stop are ignored in FAULT.
- Gating: gates may be asserted only in RAMP_UP, RUN and RAMP_DOWN.
- Per-phase dead time (phase a shown; b and c identical and independent):
  - A committed level L_a (register) and a down-counter dt_a are kept.
  - On an edge where enabled and raw_a != L_a: L_a <= raw_a, dt_a <= DEADTIME-1, Va=Van=0.
  - While dt_a != 0: decrement, both gates 0.
  - When dt_a == 0 and no new mismatch: Va=L_a, Van=~L_a.
  - Result: both gates are low for exactly DEADTIME edges, starting with the edge the change is sampled. The new side rises on the DEADTIME-th edge after that edge.
  - If raw_a toggles again during dead time, the counter reloads and L_a follows raw_a.
- On entry to RAMP_UP from IDLE, each phase loads L=raw and dt=DEADTIME-1. No gate asserts before DEADTIME edges have elapsed.
- Invariant: Va&Van, Vb&Vbn and Vc&Vcn are never 1, in any cycle, including through reset and fault.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously -> all gates 0, mod_index=0 and state=0 before the next clk edge; they stay so until release.
- Soft start with DEADTIME=4, RAMP_DIV=4, RAMP_STEP=16384, start pulse -> mod_index 16384, 32768, 49152, 65535 every 4 clocks; state=2 on the edge mod_index hits 65535.
- Dead time with raw_a held 1 then stepped to 0 in RUN -> Va=0 at the sampling edge, Van=0 for 4 edges, Van=1 on the 4th edge after. A 2-clock raw_a glitch during dead time -> counter reloads and no overlap occurs.
- Soft stop from RUN, stop pulse -> mod_index 49151, 32767, 16383, 0 every 4 clocks; state=0 and all gates 0 on the edge mod_index=0. start+stop in the same cycle -> stop wins.
- Fault in RAMP_UP, fault_n=0 for 1 cycle -> next edge state=4, gates 0, mod_index=0. clear while fault_n=0 -> stays 4. clear with fault_n=1 -> state=0.
- Randomized raw_a/b/c with random start/stop/fault over 1e5 cycles -> no complementary pair is ever simultaneously 1, and mod_index stays within 0..65535.

Source files
------------

// File: rtl/inverter_sequencer.sv
// Purpose : soft start/stop and fault sequencing for a 3-phase PWM inverter,
//           plus per-phase dead-time insertion on the six gate drives.
// Latency : all outputs are registered; every input acts on the next clk edge.
// Backpressure: none; raw comparator inputs are sampled every cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           run request / soft-stop request (stop has priority)
//   fault_n, clear        active-low fault (latches FAULT) / leave FAULT
//   raw_a, raw_b, raw_c   comparator decisions (sine > triangle)
//   mod_index             modulation index to the sine generator
//   Va..Vcn               complementary gate drives
//   state, fault_latched  sequencer state, high while in FAULT
module inverter_sequencer #(
    parameter int unsigned DEADTIME  = 8,
    parameter int unsigned RAMP_DIV  = 1024,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned MI_MAX    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fault_n,
    input  logic        clear,
    input  logic        raw_a,
    input  logic        raw_b,
    input  logic        raw_c,
    output logic [15:0] mod_index,
    output logic        Va,
    output logic        Van,
    output logic        Vb,
    output logic        Vbn,
    output logic        Vc,
    output logic        Vcn,
    output logic [2:0]  state,
    output logic        fault_latched
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DT_LOAD    = DW'(DEADTIME - 1);
    localparam logic [16:0]   STEP17     = 17'(RAMP_STEP);
    localparam logic [16:0]   MAX17      = 17'(MI_MAX);
    localparam logic [15:0]   MAX16      = 16'(MI_MAX);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     mod_q, mod_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            fault_q, fault_d;

    // Per-phase committed level, dead-time counter and gate registers (index 0=a,1=b,2=c)
    logic [2:0]          lvl_q, lvl_d;
    logic [2:0][DW-1:0]  dt_q, dt_d;
    logic [2:0]          hi_q, hi_d;
    logic [2:0]          lo_q, lo_d;

    logic [2:0]  raw_v;
    logic        presc_wrap;
    logic [16:0] mod_up;
    logic        gate_en;
    logic        phase_load;

    assign raw_v      = {raw_c, raw_b, raw_a};
    assign presc_wrap = (presc_q == PRESC_LAST);
    // 17-bit sum so the clamp to MI_MAX sees any carry out of 16 bits
    assign mod_up     = {1'b0, mod_q} + STEP17;

    // ------------------------------------------------------------------
    // Sequencer next state: fault beats stop, stop beats start.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        presc_d = presc_q;

        if (!fault_n) begin
            state_d = ST_FAULT;
            mod_d   = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    mod_d   = '0;
                    presc_d = '0;
                    if (start && !stop) begin
                        state_d = ST_RAMP_UP;
                    end
                end

                ST_RAMP_UP: begin
                    if (stop) begin
                        // index is held; ramp-down restarts its own prescale period
                        state_d = ST_RAMP_DOWN;
                        presc_d = '0;
                    end else if (presc_wrap) begin
                        presc_d = '0;
                        if (mod_up >= MAX17) begin
                            mod_d   = MAX16;
                            state_d = ST_RUN;
                        end else begin
                            mod_d = mod_up[15:0];
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end

                ST_RUN: begin
                    mod_d   = MAX16;
                    presc_d = '0;
                    if (stop) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end

                ST_RAMP_DOWN: begin
                    if (start && !stop) begin
                        state_d = ST_RAMP_UP;
                        presc_d = '0;
                    end else if (presc_wrap) begin
                        presc_d = '0;
                        // strictly greater: a step landing exactly on 0 ends the ramp
                        if ({1'b0, mod_q} > STEP17) begin
                            mod_d = mod_q - STEP17[15:0];
                        end else begin
                            mod_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end

                ST_FAULT: begin
                    mod_d   = '0;
                    presc_d = '0;
                    if (clear) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    mod_d   = '0;
                    presc_d = '0;
                end
            endcase
        end

        fault_d = (state_d == ST_FAULT);
    end

    // Gates follow the state being entered, so leaving the run states
    // (to IDLE or FAULT) drops them on the same edge.
    assign gate_en    = (state_d == ST_RAMP_UP) || (state_d == ST_RUN) ||
                        (state_d == ST_RAMP_DOWN);
    // Starting from IDLE forces a full dead time before any gate can rise.
    assign phase_load = (state_q == ST_IDLE) && (state_d == ST_RAMP_UP);

    // ------------------------------------------------------------------
    // Dead-time insertion, one independent lane per phase.
    // Any change on raw reloads the counter, so both gates stay low for
    // DEADTIME edges counted from the last change sampled.
    // ------------------------------------------------------------------
    always_comb begin
        lvl_d = lvl_q;
        dt_d  = dt_q;
        hi_d  = '0;
        lo_d  = '0;
        for (int k = 0; k < 3; k++) begin
            if (!gate_en) begin
                dt_d[k] = '0;
            end else if (phase_load || (raw_v[k] != lvl_q[k])) begin
                lvl_d[k] = raw_v[k];
                dt_d[k]  = DT_LOAD;
            end else if (dt_q[k] != '0) begin
                dt_d[k] = dt_q[k] - DW'(1);
            end else begin
                hi_d[k] = lvl_q[k];
                lo_d[k] = ~lvl_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mod_q   <= '0;
            presc_q <= '0;
            fault_q <= 1'b0;
            lvl_q   <= '0;
            dt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            presc_q <= presc_d;
            fault_q <= fault_d;
            lvl_q   <= lvl_d;
            dt_q    <= dt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mod_index     = mod_q;
    assign state         = state_q;
    assign fault_latched = fault_q;
    assign Va            = hi_q[0];
    assign Van           = lo_q[0];
    assign Vb            = hi_q[1];
    assign Vbn           = lo_q[1];
    assign Vc            = hi_q[2];
    assign Vcn           = lo_q[2];

endmodule
